// File: rtl/vga_pkg.sv
// Shared video-path definitions: default RAM geometry, arbiter grant encoding
// and the write-FIFO entry width helper.
package vga_pkg;

    localparam int unsigned VGA_ADDR_W = 13;
    localparam int unsigned VGA_DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;

    // A FIFO entry packs {addr, data}.
    function automatic int unsigned fifo_entry_w(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write buffer for host VRAM writes; pointers carry one extra
// wrap bit so full/empty fall out of an MSB compare with no separate count.
module vram_wr_fifo
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH = fifo_entry_w(VGA_ADDR_W, VGA_DATA_W),
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                     (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[IDX_W-1:0]];

    // A full FIFO refuses the push even while popping: no pass-through path.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + PTR_W'(do_push);
        rptr_d = rptr_q + PTR_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[IDX_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, buffered host writes
// drain into the cycles the scanout leaves free.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W     = VGA_ADDR_W,
    parameter int unsigned DATA_W     = VGA_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned ENTRY_W = fifo_entry_w(ADDR_W, DATA_W);

    grant_e             grant;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    vram_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (wr_valid),
        .wdata_i ({wr_addr, wr_data}),
        .pop_i   (grant == GNT_WRITE),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_addr, head_data} = head;

    always_comb begin
        grant = GNT_IDLE;
        if (rd_req) begin
            grant = GNT_READ;
        end else if (!fifo_empty) begin
            grant = GNT_WRITE;
        end
    end

    // Write enable is masked by reset so an in-flight drain is dropped cleanly.
    assign ram_addr  = (grant == GNT_WRITE) ? head_addr : rd_addr;
    assign ram_we    = (grant == GNT_WRITE) && reset_n;
    assign ram_wdata = head_data;

    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_rdata;
    assign wr_ready  = !fifo_full;
    assign busy      = !fifo_empty;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (wr_valid && !wr_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            rd_valid_q  <= rd_req;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model whose
// unwritten words read back as addr[7:0]^8'h5C.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic [CW-1:0] stall_cnt;
    logic          stall_clr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned we_in_rst = 0;
    int unsigned we_in_rd = 0;
    int unsigned we_blk = 0;

    logic [DW-1:0] mem [1<<AW];
    bit            seen [1<<AW];

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .CNT_W      (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5C;
    endfunction

    always @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr]  <= ram_wdata;
            seen[ram_addr] <= 1'b1;
        end
        ram_rdata <= seen[ram_addr] ? mem[ram_addr] : pat(ram_addr);
        if (ram_we && !reset_n)              we_in_rst <= we_in_rst + 1;
        if (ram_we && rd_req)                we_in_rd  <= we_in_rd + 1;
        if (ram_we && ram_addr[12:8] == 5'h1C) we_blk  <= we_blk + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held 3 edges with a write offered
        reset_n = 1'b0; rd_req = 1'b0; rd_addr = '0; stall_clr = 1'b0;
        wr_valid = 1'b1; wr_addr = 13'h0ABC; wr_data = 8'h77;
        repeat (3) begin
            @(negedge clock); #1;
            check_eq("t1_we_in_reset", 32'(ram_we), 32'd0);
        end
        reset_n = 1'b1; wr_valid = 1'b0; #1;
        check_eq("t1_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("t1_rd_valid", 32'(rd_valid), 32'd0);

        // 2: 640 reads with 4 writes queued, then the drain
        for (int c = 0; c <= 644; c++) begin
            @(negedge clock);
            rd_req   = (c < 640);
            rd_addr  = (c < 640) ? AW'(c) : '0;
            wr_valid = (c < 5);
            wr_addr  = AW'(32'h1000 + c);
            wr_data  = DW'(8'h10 + c);
            #1;
            if (c < 4) check_eq("t2_ready_fill", 32'(wr_ready), 32'd1);
            if (c == 4) begin
                check_eq("t2_fifth_ready", 32'(wr_ready), 32'd0);
                check_eq("t2_busy", 32'(busy), 32'd1);
            end
            if (c >= 1 && c <= 640) begin
                check_eq("t2_rd_valid", 32'(rd_valid), 32'd1);
                check_eq("t2_rd_data", 32'(rd_data), 32'(pat(AW'(c - 1))));
            end
            if (c >= 640 && c < 644) begin
                check_eq("t2_drain_we", 32'(ram_we), 32'd1);
                check_eq("t2_drain_addr", 32'(ram_addr), 32'h1000 + 32'(c - 640));
                check_eq("t2_drain_data", 32'(ram_wdata), 32'h10 + 32'(c - 640));
            end
            if (c == 640) check_eq("t2_full_pop_ready", 32'(wr_ready), 32'd0);
            if (c == 641) check_eq("t2_ready_after_pop", 32'(wr_ready), 32'd1);
            if (c == 644) begin
                check_eq("t2_end_we", 32'(ram_we), 32'd0);
                check_eq("t2_end_busy", 32'(busy), 32'd0);
                check_eq("t2_end_rd_valid", 32'(rd_valid), 32'd0);
            end
        end
        check_eq("t2_we_during_read", we_in_rd, 32'd0);

        // 3: single idle write
        @(negedge clock);
        rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 13'h0123; wr_data = 8'hA5; #1;
        check_eq("t3_busy_before", 32'(busy), 32'd0);
        check_eq("t3_we_before", 32'(ram_we), 32'd0);
        @(negedge clock);
        wr_valid = 1'b0; #1;
        check_eq("t3_we", 32'(ram_we), 32'd1);
        check_eq("t3_addr", 32'(ram_addr), 32'h0123);
        check_eq("t3_data", 32'(ram_wdata), 32'hA5);
        check_eq("t3_busy", 32'(busy), 32'd1);
        @(negedge clock); #1;
        check_eq("t3_busy_after", 32'(busy), 32'd0);
        check_eq("t3_we_after", 32'(ram_we), 32'd0);

        // 4: full FIFO with rd_req toggling
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            rd_req = 1'b1; rd_addr = '0; wr_valid = 1'b1;
            wr_addr = AW'(32'h1800 + j); wr_data = DW'(8'hC0 + j); #1;
        end
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            wr_valid = 1'b0;
            rd_req   = (k < 8) && (k % 2 == 0);
            rd_addr  = (k == 0) ? 13'h0123 : AW'(32'h0200 + k);
            #1;
            if (k == 0) check_eq("t4_full_ready", 32'(wr_ready), 32'd0);
            if (k == 2) check_eq("t4_ready_again", 32'(wr_ready), 32'd1);
            if (k < 8 && k % 2 == 0) begin
                check_eq("t4_rd_we", 32'(ram_we), 32'd0);
                check_eq("t4_rd_addr", 32'(ram_addr), (k == 0) ? 32'h0123 : 32'h0200 + 32'(k));
                if (k > 0) check_eq("t4_rd_valid_low", 32'(rd_valid), 32'd0);
            end
            if (k % 2 == 1) begin
                check_eq("t4_wr_we", 32'(ram_we), 32'd1);
                check_eq("t4_wr_addr", 32'(ram_addr), 32'h1800 + 32'((k - 1) / 2));
                check_eq("t4_wr_data", 32'(ram_wdata), 32'hC0 + 32'((k - 1) / 2));
                check_eq("t4_rd_valid", 32'(rd_valid), 32'd1);
                check_eq("t4_rd_data", 32'(rd_data),
                         (k == 1) ? 32'hA5 : 32'(pat(AW'(32'h0200 + k - 1))));
            end
            if (k == 8) begin
                check_eq("t4_end_we", 32'(ram_we), 32'd0);
                check_eq("t4_end_busy", 32'(busy), 32'd0);
            end
        end

        // 5: stall counter saturation and clear
        @(negedge clock);
        stall_clr = 1'b1; rd_req = 1'b1; #1;
        @(negedge clock);
        stall_clr = 1'b0; #1;
        check_eq("t5_cleared", 32'(stall_cnt), 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            wr_valid = 1'b1; wr_addr = AW'(32'h1A00 + j); wr_data = DW'(8'hD0 + j); #1;
        end
        for (int s = 1; s <= 20; s++) begin
            @(negedge clock); #1;
            check_eq("t5_stall_cnt", 32'(stall_cnt), (s - 1 > 15) ? 32'd15 : 32'(s - 1));
        end
        @(negedge clock);
        stall_clr = 1'b1; #1;
        check_eq("t5_saturated", 32'(stall_cnt), 32'd15);
        check_eq("t5_we_while_reading", 32'(ram_we), 32'd0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clock);
            stall_clr = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; #1;
            if (d == 0) check_eq("t5_clr_priority", 32'(stall_cnt), 32'd0);
            check_eq("t5_drain_we", 32'(ram_we), 32'd1);
            check_eq("t5_drain_addr", 32'(ram_addr), 32'h1A00 + 32'(d));
            check_eq("t5_drain_data", 32'(ram_wdata), 32'hD0 + 32'(d));
        end

        // 6: reset on the first drain cycle
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            rd_req = 1'b1; wr_valid = 1'b1;
            wr_addr = AW'(32'h1C00 + j); wr_data = DW'(8'hE0 + j); #1;
        end
        @(negedge clock);
        wr_valid = 1'b0; rd_req = 1'b0; reset_n = 1'b0; #1;
        check_eq("t6_we_in_reset", 32'(ram_we), 32'd0);
        check_eq("t6_busy_queued", 32'(busy), 32'd1);
        @(negedge clock);
        reset_n = 1'b1; #1;
        check_eq("t6_busy_after", 32'(busy), 32'd0);
        check_eq("t6_ready_after", 32'(wr_ready), 32'd1);
        repeat (3) begin
            @(negedge clock); #1;
            check_eq("t6_no_late_we", 32'(ram_we), 32'd0);
        end
        check_eq("t6_dropped_writes", we_blk, 32'd0);
        check_eq("t1_t6_we_in_reset", we_in_rst, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
